// File: rtl/picorv32_bram_bridge.sv
// picorv32 native bus to single-port BRAM plus a timed-out valid/ready IO port.
// BRAM: ready one cycle after valid; IO: ready one cycle after io_ready or after the timeout.
module picorv32_bram_bridge #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BRAM_BASE  = 32'h0000_0000,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_din,
  output logic [3:0]            bram_we,
  input  logic [31:0]           bram_dout,
  output logic                  io_valid,
  output logic [31:0]           io_addr,
  output logic [31:0]           io_wdata,
  output logic [3:0]            io_wstrb,
  input  logic                  io_ready,
  input  logic [31:0]           io_rdata,
  output logic                  bus_err,
  output logic [15:0]           err_count
);

  localparam logic [31:0] WIN_MASK = ~((32'd4 << ADDR_WIDTH) - 32'd1);
  localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BRAM_ACK, IO_REQ, IO_ACK} state_t;

  state_t        state_q, state_d;
  logic          skip_q, skip_d;
  logic          io_valid_q, io_valid_d;
  logic [31:0]   io_addr_q, io_addr_d;
  logic [31:0]   io_wdata_q, io_wdata_d;
  logic [3:0]    io_wstrb_q, io_wstrb_d;
  logic [31:0]   io_data_q, io_data_d;
  logic          bus_err_q, bus_err_d;
  logic [15:0]   err_count_q, err_count_d;
  logic [TW-1:0] timer_q, timer_d;

  logic hit;
  logic accept;

  assign hit    = (mem_addr & WIN_MASK) == BRAM_BASE;
  // The core still shows the finished request for one cycle after an ack.
  assign accept = (state_q == IDLE) && !skip_q && mem_valid;

  always_comb begin
    state_d     = state_q;
    skip_d      = 1'b0;
    io_valid_d  = io_valid_q;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
    io_wstrb_d  = io_wstrb_q;
    io_data_d   = io_data_q;
    bus_err_d   = 1'b0;
    err_count_d = err_count_q;
    timer_d     = timer_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            state_d = BRAM_ACK;
          end else begin
            io_addr_d  = mem_addr;
            io_wdata_d = mem_wdata;
            io_wstrb_d = mem_wstrb;
            io_valid_d = 1'b1;
            timer_d    = '0;
            state_d    = IO_REQ;
          end
        end
      end
      BRAM_ACK: begin
        state_d = IDLE;
        skip_d  = 1'b1;
      end
      IO_REQ: begin
        if (io_ready) begin
          io_data_d  = io_rdata;
          io_valid_d = 1'b0;
          state_d    = IO_ACK;
        end else if ((TIMEOUT != 0) && (timer_q == TLAST)) begin
          io_data_d  = ERR_DATA;
          io_valid_d = 1'b0;
          bus_err_d  = 1'b1;
          if (err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
          end
          state_d = IO_ACK;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      IO_ACK: begin
        state_d = IDLE;
        skip_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      skip_q      <= 1'b0;
      io_valid_q  <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
      io_wstrb_q  <= '0;
      io_data_q   <= '0;
      bus_err_q   <= 1'b0;
      err_count_q <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      io_valid_q  <= io_valid_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
      io_wstrb_q  <= io_wstrb_d;
      io_data_q   <= io_data_d;
      bus_err_q   <= bus_err_d;
      err_count_q <= err_count_d;
      timer_q     <= timer_d;
    end
  end

  // BRAM data arrives combinationally in the ack cycle, one cycle after the address.
  assign mem_ready = (state_q == BRAM_ACK) || (state_q == IO_ACK);
  assign mem_rdata = (state_q == BRAM_ACK) ? bram_dout :
                     (state_q == IO_ACK)   ? io_data_q : 32'h0;

  assign bram_addr = mem_addr[ADDR_WIDTH+1:2];
  assign bram_din  = mem_wdata;
  assign bram_we   = (accept && hit && !rst) ? mem_wstrb : 4'h0;

  assign io_valid  = io_valid_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;
  assign io_wstrb  = io_wstrb_q;
  assign bus_err   = bus_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_picorv32_bram_bridge.sv
// Bench for picorv32_bram_bridge: BRAM model, scripted IO responder, rdata scoreboard.
module tb_picorv32_bram_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  bram_addr;
  logic [31:0] bram_din;
  logic [3:0]  bram_we;
  logic [31:0] bram_dout = '0;
  logic        io_valid;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        io_ready = 1'b0;
  logic [31:0] io_rdata = '0;
  logic        bus_err;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

  // {check_enable, expected_rdata}; BRAM writes return old contents, so unchecked
  logic [32:0] exp_q[$];

  int we_cnt = 0, iov_cnt = 0, berr_cnt = 0, rdy_cnt = 0;
  logic [7:0] we_addr = '0;
  logic [3:0] we_val  = '0;

  logic [31:0] bram [0:255];

  picorv32_bram_bridge #(
    .ADDR_WIDTH(8), .BRAM_BASE(32'h0000_0000), .TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_dout(bram_dout),
    .io_valid(io_valid), .io_addr(io_addr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
    .io_ready(io_ready), .io_rdata(io_rdata),
    .bus_err(bus_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bram_we[b]) bram[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
    end
    bram_dout <= bram[bram_addr];
  end

  always @(negedge clk) begin
    if (bram_we != 4'h0) begin
      we_cnt++;
      we_addr = bram_addr;
      we_val  = bram_we;
    end
    if (io_valid) iov_cnt++;
    if (bus_err) berr_cnt++;
    if (mem_ready) begin
      rdy_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready: mem_ready=1 with no request outstanding, rdata=%h", mem_rdata);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if (e[32] && mem_rdata !== e[31:0]) begin
          bad++;
          $display("FAIL rdata: got %h expected %h", mem_rdata, e[31:0]);
        end
      end
    end else if (!rst) begin
      total++;
      if (mem_rdata !== 32'h0) begin
        bad++;
        $display("FAIL rdata_idle: got %h expected 00000000 while mem_ready=0", mem_rdata);
      end
    end
  end

  // Starts and ends one time unit after a rising edge.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic chk, input logic [31:0] exp, output int lat);
    logic seen;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    exp_q.push_back({chk, exp});
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL txn_timeout: addr %h got no mem_ready within 40 cycles", a);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = 4'h0;
  endtask

  task automatic io_respond(input int d, input logic [31:0] data, input logic [31:0] ea,
                            input logic [31:0] ewd, input logic [3:0] ews);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (io_valid) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL io_valid_wait: io_valid never rose, got %b expected 1", io_valid);
    end else begin
      for (int k = 0; k < d; k++) begin
        total++;
        if (io_valid !== 1'b1 || io_addr !== ea || io_wdata !== ewd || io_wstrb !== ews) begin
          bad++;
          $display("FAIL io_stable: got v=%b a=%h d=%h s=%h expected v=1 a=%h d=%h s=%h",
                   io_valid, io_addr, io_wdata, io_wstrb, ea, ewd, ews);
        end
        @(posedge clk); #1;
      end
      io_ready = 1'b1; io_rdata = data;
      @(posedge clk); #1;
      io_ready = 1'b0; io_rdata = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_valid = 1'b1; mem_addr = 32'h20; mem_wstrb = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || bram_we !== 4'h0 || io_valid !== 1'b0 ||
        io_addr !== 32'h0 || io_wdata !== 32'h0 || io_wstrb !== 4'h0 || bus_err !== 1'b0 ||
        err_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b rd=%h we=%h iov=%b ioa=%h iod=%h ios=%h berr=%b cnt=%h expected all 0",
               mem_ready, mem_rdata, bram_we, io_valid, io_addr, io_wdata, io_wstrb, bus_err, err_count);
    end
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_bram_rw;
    int lat, w0;
    w0 = we_cnt;
    do_txn(32'h10, 32'h1122_3344, 4'hF, 1'b0, 32'h0, lat);
    total++;
    if (we_cnt - w0 != 1 || we_addr !== 8'd4 || we_val !== 4'hF || lat != 1) begin
      bad++;
      $display("FAIL bram_write: we_cycles=%0d addr=%0d we=%h lat=%0d expected 1,4,F,1",
               we_cnt - w0, we_addr, we_val, lat);
    end
    idle(2);
    do_txn(32'h10, 32'h0, 4'h0, 1'b1, 32'h1122_3344, lat);
    total++;
    if (lat != 1) begin
      bad++;
      $display("FAIL bram_read_lat: got %0d expected 1", lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat0, lat1, w0, v0;
    w0 = we_cnt;
    do_txn(32'h0, 32'hAAAA_0000, 4'hF, 1'b0, 32'h0, lat0);
    do_txn(32'h4, 32'hBBBB_0004, 4'hF, 1'b0, 32'h0, lat1);
    total++;
    if (we_cnt - w0 != 2 || lat1 != 2) begin
      bad++;
      $display("FAIL b2b_write: we_cycles=%0d lat=%0d expected 2,2", we_cnt - w0, lat1);
    end
    idle(2);
    w0 = we_cnt; v0 = iov_cnt;
    do_txn(32'h0, 32'h0, 4'h0, 1'b1, 32'hAAAA_0000, lat0);
    do_txn(32'h4, 32'h0, 4'h0, 1'b1, 32'hBBBB_0004, lat1);
    total++;
    if (lat0 != 1 || lat1 != 2 || we_cnt != w0 || iov_cnt != v0) begin
      bad++;
      $display("FAIL b2b_read: lat0=%0d lat1=%0d we_cycles=%0d io_cycles=%0d expected 1,2,0,0",
               lat0, lat1, we_cnt - w0, iov_cnt - v0);
    end
    idle(2);
  endtask

  task automatic test_io;
    int lat, w0;
    w0 = we_cnt;
    fork
      do_txn(32'h1000_0000, 32'hA5A5_0001, 4'hF, 1'b1, 32'h55, lat);
      io_respond(3, 32'h55, 32'h1000_0000, 32'hA5A5_0001, 4'hF);
    join
    total++;
    if (lat != 5 || we_cnt != w0) begin
      bad++;
      $display("FAIL io_write: lat=%0d we_cycles=%0d expected 5,0", lat, we_cnt - w0);
    end
    idle(2);
    fork
      do_txn(32'h1000_0004, 32'h0, 4'h0, 1'b1, 32'h55, lat);
      io_respond(1, 32'h55, 32'h1000_0004, 32'h0, 4'h0);
    join
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL io_read_lat: got %0d expected 3", lat);
    end
    idle(2);
  endtask

  task automatic test_timeout;
    int lat, v0, e0;
    v0 = iov_cnt; e0 = berr_cnt;
    do_txn(32'h2000_0000, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, lat);
    total++;
    if (iov_cnt - v0 != TO || berr_cnt - e0 != 1 || err_count !== 16'd1 || lat != TO + 1) begin
      bad++;
      $display("FAIL timeout: io_cycles=%0d berr=%0d cnt=%0d lat=%0d expected %0d,1,1,%0d",
               iov_cnt - v0, berr_cnt - e0, err_count, lat, TO, TO + 1);
    end
    idle(2);
    force dut.err_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.err_count_q;
    e0 = berr_cnt;
    do_txn(32'h2000_0000, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, lat);
    total++;
    if (err_count !== 16'hFFFF || berr_cnt - e0 != 1) begin
      bad++;
      $display("FAIL err_saturate: cnt=%h berr=%0d expected FFFF,1", err_count, berr_cnt - e0);
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    int r0, lat;
    logic seen;
    mem_valid = 1'b1; mem_addr = 32'h3000_0000; mem_wstrb = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (io_valid) seen = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    r0 = rdy_cnt;
    @(negedge clk);
    total++;
    if (!seen || io_valid !== 1'b0 || err_count !== 16'h0 || mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: seen=%b iov=%b cnt=%h rdy=%b expected 1,0,0000,0",
               seen, io_valid, err_count, mem_ready);
    end
    idle(TO + 4);
    total++;
    if (rdy_cnt != r0 || err_count !== 16'h0 || bus_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_abandon: readies=%0d cnt=%h berr=%b expected 0,0000,0",
               rdy_cnt - r0, err_count, bus_err);
    end
    do_txn(32'h10, 32'h0, 4'h0, 1'b1, 32'h1122_3344, lat);
    total++;
    if (lat != 1) begin
      bad++;
      $display("FAIL reset_idle_lat: got %0d expected 1", lat);
    end
    idle(2);
  endtask

  task automatic test_ready_vs_timeout;
    int lat, e0;
    e0 = berr_cnt;
    fork
      do_txn(32'h3000_0008, 32'h0, 4'h0, 1'b1, 32'h1234_5678, lat);
      io_respond(TO - 1, 32'h1234_5678, 32'h3000_0008, 32'h0, 4'h0);
    join
    total++;
    if (lat != TO + 1 || berr_cnt != e0 || err_count !== 16'h0) begin
      bad++;
      $display("FAIL ready_wins: lat=%0d berr=%0d cnt=%h expected %0d,0,0000",
               lat, berr_cnt - e0, err_count, TO + 1);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_bram_rw();
    test_back_to_back();
    test_io();
    test_timeout();
    test_reset_mid();
    test_ready_vs_timeout();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expected responses never arrived, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
